// File: rtl/ysyx_pc_pkg.sv
// Shared types for the PC generator: next-PC source encoding, FSM states
// and the default reset vector.
package ysyx_pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ  = 3'b000,
    PC_JALR = 3'b001,
    PC_JAL  = 3'b010,
    PC_BR   = 3'b100,
    PC_CSR  = 3'b101
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RESET    = 2'd0,
    ST_OFFER    = 2'd1,
    ST_WAIT_UPD = 2'd2
  } pc_state_e;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_ras.sv
// Circular return-address stack: pushes overwrite the oldest entry when full,
// pops on empty are ignored, push+pop together replaces the top entry.
module ysyx_ras #(
  parameter int  XLEN      = 32,
  parameter int  RAS_DEPTH = 8,
  localparam int PTR_W     = $clog2(RAS_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [XLEN-1:0]  push_data,
  output logic [XLEN-1:0]  top,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(RAS_DEPTH);

  logic [XLEN-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] top_idx;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    if (push && pop && (count_q != '0)) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q - 1'b1;
    end else if (push) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + 1'b1;
      if (count_q != FULL_COUNT) count_d = count_q + 1'b1;
    end else if (pop && (count_q != '0)) begin
      ptr_d   = ptr_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count_q gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_data;
  end

  assign top_idx = ptr_q - 1'b1;
  assign top     = (count_q != '0) ? mem_q[top_idx] : '0;
  assign count   = count_q;

endmodule

// File: rtl/ysyx_pc_gen_ras.sv
// Architectural PC holder: offers pc to fetch, commits one next-PC update per
// instruction, flags misaligned targets and drives the return-address stack.
module ysyx_pc_gen_ras
  import ysyx_pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEFAULT),
  parameter int              RAS_DEPTH = 8,
  localparam int             RAS_PTR_W = $clog2(RAS_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [XLEN-1:0]      pc,
  output logic                 pc_valid,
  input  logic                 pc_ready,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [2:0]           pc_sel,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      imm_data,
  input  logic                 br_taken,
  input  logic [XLEN-1:0]      csr_pc,
  input  logic                 is_call,
  input  logic                 is_ret,
  output logic [XLEN-1:0]      ras_top,
  output logic [RAS_PTR_W:0]   ras_count,
  output logic                 misalign_err
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] seq_pc, jalr_sum, next_pc;
  logic            commit;
  logic            ras_push, ras_pop;

  assign seq_pc   = pc_q + XLEN'(4);
  assign jalr_sum = rs1_data + imm_data;

  always_comb begin
    next_pc = seq_pc;
    case (pc_sel_e'(pc_sel))
      PC_JALR: next_pc = {jalr_sum[XLEN-1:1], 1'b0};
      PC_JAL:  next_pc = pc_q + imm_data;
      PC_BR:   next_pc = br_taken ? (pc_q + imm_data) : seq_pc;
      PC_CSR:  next_pc = csr_pc;
      default: next_pc = seq_pc;
    endcase
  end

  // Moore handshake outputs: pc_valid and upd_ready are never high together.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    commit     = 1'b0;
    pc_valid   = 1'b0;
    upd_ready  = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_OFFER;
      ST_OFFER: begin
        pc_valid = 1'b1;
        if (pc_ready) state_d = ST_WAIT_UPD;
      end
      ST_WAIT_UPD: begin
        upd_ready = 1'b1;
        if (upd_valid) begin
          commit     = 1'b1;
          pc_d       = next_pc;
          misalign_d = next_pc[1];
          state_d    = ST_OFFER;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RESET;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  // Call/return hints only count on jal/jalr commits; the link is the old pc+4.
  assign ras_push = commit && is_call &&
                    ((pc_sel_e'(pc_sel) == PC_JALR) || (pc_sel_e'(pc_sel) == PC_JAL));
  assign ras_pop  = commit && is_ret && (pc_sel_e'(pc_sel) == PC_JALR);

  ysyx_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq_pc),
    .top       (ras_top),
    .count     (ras_count)
  );

  assign pc           = pc_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_ysyx_pc_gen_ras.sv
// Directed bench for ysyx_pc_gen_ras: a behavioural PC/RAS model queues the
// expected state at each update and the scoreboard compares after commit.
module tb_ysyx_pc_gen_ras;

  localparam int          DEPTH = 8;
  localparam logic [31:0] RV    = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        upd_valid;
  logic        upd_ready;
  logic [2:0]  pc_sel;
  logic [31:0] rs1_data;
  logic [31:0] imm_data;
  logic        br_taken;
  logic [31:0] csr_pc;
  logic        is_call;
  logic        is_ret;
  logic [31:0] ras_top;
  logic [3:0]  ras_count;
  logic        misalign_err;

  typedef struct packed {
    logic [31:0] pc;
    logic        mis;
    logic [31:0] cnt;
    logic [31:0] top;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  ysyx_pc_gen_ras dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .pc_ready     (pc_ready),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .pc_sel       (pc_sel),
    .rs1_data     (rs1_data),
    .imm_data     (imm_data),
    .br_taken     (br_taken),
    .csr_pc       (csr_pc),
    .is_call      (is_call),
    .is_ret       (is_ret),
    .ras_top      (ras_top),
    .ras_count    (ras_count),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_top();
    return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
  endfunction

  // Called at a negedge; waits for the offer, accepts it, lands in WAIT_UPD.
  task automatic offer_accept();
    int waited = 0;
    pc_ready = 1'b1;
    while (pc_valid !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (pc_valid !== 1'b1) begin
      n_tests++;
      n_fail++;
      $error("FAIL offer_timeout: pc_valid observed %b required 1", pc_valid);
    end
    check("offer_pc", pc, m_pc);
    check("offer_upd_ready", 32'(upd_ready), 32'd0);
    @(negedge clk);
    pc_ready = 1'b0;
    check("wait_pc_valid", 32'(pc_valid), 32'd0);
    check("wait_upd_ready", 32'(upd_ready), 32'd1);
  endtask

  task automatic update(input logic [2:0] sel, input logic [31:0] rs1, input logic [31:0] imm,
                        input logic br, input logic [31:0] csr, input logic call, input logic ret);
    exp_t        e;
    logic [31:0] sum, link, nxt;
    bit          do_push, do_pop;
    pc_sel = sel; rs1_data = rs1; imm_data = imm; br_taken = br; csr_pc = csr;
    is_call = call; is_ret = ret; upd_valid = 1'b1;
    sum  = rs1 + imm;
    link = m_pc + 32'd4;
    case (sel)
      3'b001:  nxt = sum & 32'hFFFF_FFFE;
      3'b010:  nxt = m_pc + imm;
      3'b100:  nxt = br ? (m_pc + imm) : link;
      3'b101:  nxt = csr;
      default: nxt = link;
    endcase
    do_push = call && (sel == 3'b001 || sel == 3'b010);
    do_pop  = ret && (sel == 3'b001);
    if (do_push && do_pop && m_ras.size() > 0) m_ras[m_ras.size()-1] = link;
    else if (do_push) begin
      m_ras.push_back(link);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    end else if (do_pop && m_ras.size() > 0) void'(m_ras.pop_back());
    m_pc  = nxt;
    e.pc  = nxt;
    e.mis = nxt[1];
    e.cnt = m_ras.size();
    e.top = m_top();
    exp_q.push_back(e);
    @(negedge clk);
    upd_valid = 1'b0; is_call = 1'b0; is_ret = 1'b0;
    e = exp_q.pop_front();
    check("upd_pc", pc, e.pc);
    check("upd_pc_valid", 32'(pc_valid), 32'd1);
    check("upd_misalign", 32'(misalign_err), 32'(e.mis));
    check("upd_ras_count", 32'(ras_count), e.cnt);
    check("upd_ras_top", ras_top, e.top);
  endtask

  task automatic step(input logic [2:0] sel, input logic [31:0] rs1, input logic [31:0] imm,
                      input logic br, input logic [31:0] csr, input logic call, input logic ret);
    offer_accept();
    update(sel, rs1, imm, br, csr, call, ret);
  endtask

  initial begin
    rst = 1'b1; pc_ready = 1'b0; upd_valid = 1'b0; pc_sel = 3'b000;
    rs1_data = '0; imm_data = '0; br_taken = 1'b0; csr_pc = '0;
    is_call = 1'b0; is_ret = 1'b0;
    m_pc = RV;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, RV);
    check("rst_pc_valid", 32'(pc_valid), 32'd0);
    check("rst_upd_ready", 32'(upd_ready), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    check("rst_ras_count", 32'(ras_count), 32'd0);
    check("rst_ras_top", ras_top, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Sequential updates: 0x80000000 -> 04 -> 08 -> 0C
    for (int i = 0; i < 3; i++) step(3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("seq_final_pc", pc, 32'h8000_000C);

    // Misaligned jalr, pulse lasts one cycle, then branch not-taken and taken
    step(3'b001, 32'h8000_1003, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
    check("jalr_pc", pc, 32'h8000_1006);
    @(negedge clk);
    check("misalign_pulse_end", 32'(misalign_err), 32'd0);
    step(3'b100, 32'h0, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    check("br_not_taken_pc", pc, 32'h8000_100A);
    step(3'b100, 32'h0, 32'h2, 1'b1, 32'h0, 1'b0, 1'b0);
    check("br_taken_pc", pc, 32'h8000_100C);

    // Address wraps modulo 2^32
    step(3'b001, 32'hFFFF_FFF0, 32'h14, 1'b0, 32'h0, 1'b0, 1'b0);
    check("jalr_wrap_pc", pc, 32'h0000_0004);

    // 9 calls saturate the RAS, then 9 returns drain it
    for (int i = 0; i < 9; i++) step(3'b010, 32'h0, 32'h10, 1'b0, 32'h0, 1'b1, 1'b0);
    check("ras_full_count", 32'(ras_count), 32'd8);
    for (int i = 0; i < 9; i++)
      step(3'b001, (m_ras.size() > 0) ? m_top() : 32'h8000_2000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("ras_empty_count", 32'(ras_count), 32'd0);
    check("ras_empty_top", ras_top, 32'd0);

    // Coroutine swap with count=2, then on an empty stack
    for (int i = 0; i < 2; i++) step(3'b010, 32'h0, 32'h20, 1'b0, 32'h0, 1'b1, 1'b0);
    step(3'b001, 32'h8000_3000, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("swap_count", 32'(ras_count), 32'd2);
    for (int i = 0; i < 2; i++) step(3'b001, m_top(), 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(3'b001, 32'h8000_4000, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("swap_empty_count", 32'(ras_count), 32'd1);

    // Call hint on a branch is ignored
    step(3'b100, 32'h0, 32'h40, 1'b1, 32'h0, 1'b1, 1'b1);

    // CSR redirect presented while fetch stalls: no effect until accepted
    pc_sel = 3'b101; csr_pc = 32'h8000_0100; upd_valid = 1'b1; pc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_pc_hold", pc, m_pc);
      check("stall_upd_ready", 32'(upd_ready), 32'd0);
      check("stall_pc_valid", 32'(pc_valid), 32'd1);
    end
    step(3'b101, 32'h0, 32'h0, 1'b0, 32'h8000_0100, 1'b0, 1'b0);
    check("csr_pc", pc, 32'h8000_0100);

    // Build count=3, then reset while waiting for an update
    while (m_ras.size() > 0) step(3'b001, m_top(), 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(3'b010, 32'h0, 32'h8, 1'b0, 32'h0, 1'b1, 1'b0);
    check("pre_rst_count", 32'(ras_count), 32'd3);
    offer_accept();
    rst = 1'b1; upd_valid = 1'b1; pc_sel = 3'b010; imm_data = 32'h40; is_call = 1'b1;
    @(negedge clk);
    rst = 1'b0; upd_valid = 1'b0; is_call = 1'b0;
    m_pc = RV;
    m_ras.delete();
    check("midrst_pc", pc, RV);
    check("midrst_pc_valid", 32'(pc_valid), 32'd0);
    check("midrst_upd_ready", 32'(upd_ready), 32'd0);
    check("midrst_ras_count", 32'(ras_count), 32'd0);
    check("midrst_ras_top", ras_top, 32'd0);
    @(negedge clk);
    check("post_rst_pc_valid", 32'(pc_valid), 32'd1);
    step(3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("post_rst_seq_pc", pc, 32'h8000_0004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_pc_gen_ras.md
Name: ysyx_pc_gen_ras

Overview:
- Parametrised next-generation program-counter unit; sits between the decode/execute stage and instruction fetch.
- Holds the architectural PC and offers it to fetch through a valid/ready handshake.
- Accepts one next-PC update per instruction through a second handshake. Sources: sequential, jal, jalr, branch, or csr/trap redirect.
- Maintains a circular return-address stack (RAS) fed by call/return hints, and flags misaligned targets.

Parameters:
- XLEN, 32, data/address width
- RESET_VEC, 32'h8000_0000, PC value loaded on reset
- RAS_DEPTH, 8, RAS entries; power of two, >= 2
- RAS_PTR_W, $clog2(RAS_DEPTH), RAS pointer width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pc  out  XLEN  current PC
- pc_valid  out  1  pc is offered to fetch
- pc_ready  in  1  fetch accepts pc
- upd_valid  in  1  next-PC update presented by execute
- upd_ready  out  1  unit accepts update
- pc_sel  in  3  001 jalr, 010 jal, 100 branch, 101 csr/trap, any other value sequential
- rs1_data  in  XLEN  jalr base
- imm_data  in  XLEN  jalr/jal/branch offset
- br_taken  in  1  branch outcome (used only when pc_sel=100)
- csr_pc  in  XLEN  mtvec/mepc target
- is_call  in  1  update is a call (jal/jalr with rd=x1/x5)
- is_ret  in  1  update is a return (jalr rs1=x1/x5, rd=x0)
- ras_top  out  XLEN  predicted return address; 0 when empty
- ras_count  out  RAS_PTR_W+1  valid RAS entries
- misalign_err  out  1  one-cycle pulse: committed target has bit1 set

Behaviour:
- State machine with states RESET, OFFER, WAIT_UPD.
  - RESET is entered on rst, regardless of state or in-flight handshakes.
  - RESET -> OFFER unconditionally on the next clk.
  - OFFER: pc_valid=1, upd_ready=0. On pc_valid&&pc_ready, go to WAIT_UPD.
  - WAIT_UPD: pc_valid=0, upd_ready=1. On upd_valid&&upd_ready, commit the update and go to OFFER.
- Reset values:
  - pc=RESET_VEC, pc_valid=0, upd_ready=0, misalign_err=0.
  - ras_count=0, ras_top=0, RAS pointer=0. RAS contents are don't-care.
- Update ignored when not in WAIT_UPD: pc_valid and upd_ready are never both 1, so an upd_valid arriving in OFFER has no effect.
- Next-PC (XLEN-bit arithmetic, wraps modulo 2^XLEN, no overflow flag):
  - 001: (rs1_data+imm_data) & ~1
  - 010: pc+imm_data
  - 100: br_taken ? pc+imm_data : pc+4
  - 101: csr_pc
  - other: pc+4
- Latency: pc shows the new value in the cycle after the update handshake, together with pc_valid=1. The handshake-to-next-offer latency is 1 cycle.
- Misalignment: if next_pc[1]=1, misalign_err pulses high for exactly the cycle after the commit. pc still loads the target; the trap decision belongs to the CSR unit.
- RAS acts only on a committed update:
  - Push (is_call, pc_sel 001/010): write pc+4 at ptr, ptr+1, count=min(count+1, RAS_DEPTH).
    - Full: ptr wraps and overwrites the oldest entry; count stays RAS_DEPTH.
  - Pop (is_ret, pc_sel=001): ptr-1, count-1.
    - Empty: no change; count stays 0, no underflow.
  - Push and pop together (coroutine swap): replace the top entry with pc+4; ptr and count unchanged. When empty, behave as a plain push.
  - is_call/is_ret with any other pc_sel: ignored.
  - ras_top = entry[ptr-1] when count>0, else 0. Combinational from registers.
- Reset mid-operation discards any pending handshake and clears the RAS.

Decomposition:
- Shared package ysyx_pc_pkg:
  - pc_sel_e encoding (PC_SEQ, PC_JALR=3'b001, PC_JAL=3'b010, PC_BR=3'b100, PC_CSR=3'b101)
  - state enum
  - RESET_VEC default
- One natural sub-module: ysyx_ras.
  - Circular stack with push/pop/count/top, parametrised on XLEN and RAS_DEPTH.
  - Top level keeps the FSM, next-PC mux and misalign logic.

Test Plan:
- Reset then pc_ready=1, upd_valid=1 with pc_sel=000 for 3 updates -> pc sequence 0x80000000, 0x80000004, 0x80000008, 0x8000000C; pc_valid alternates 1,0.
- jalr: rs1_data=0x80001003, imm_data=0x4 -> pc=0x80001006 and misalign_err=1 for one cycle. Then branch with br_taken=0, imm_data=0x100 -> pc=0x8000100A.
- 9 jal calls with is_call=1 (RAS_DEPTH=8) -> ras_count saturates at 8, ras_top=last pc+4. Then 9 rets -> count reaches 0, ras_top=0, 9th pop leaves state unchanged.
- Call+ret together with count=2 -> count stays 2, top replaced by pc+4. On empty RAS -> count becomes 1.
- pc_sel=101, csr_pc=0x80000100 while pc_ready held low 3 cycles -> pc holds, upd_ready=0. Then pc_ready=1 and the update commits -> pc=0x80000100.
- rst asserted in WAIT_UPD with RAS count=3 -> next cycle pc=RESET_VEC, pc_valid=0, ras_count=0; one cycle later pc_valid=1.
